// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
//   Shared definitions for the key_debounce block:
//     KEY_W        number of key channels (4)
//     key_state_t  per-channel debounce FSM state
//     db_cnt()     debounce length in sys_clk cycles
//     long_cnt()   long-press threshold in sys_clk cycles
//     cnt_width()  counter width for a count of n, never below 1 bit
// ----------------------------------------------------------------------------
package key_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE_UP   = 2'd0,
        WAIT_DOWN = 2'd1,
        HELD_DOWN = 2'd2,
        WAIT_UP   = 2'd3
    } key_state_t;

    function automatic int unsigned db_cnt(input int unsigned clk_freq_hz,
                                           input int unsigned debounce_ms);
        return clk_freq_hz / 1000 * debounce_ms;
    endfunction

    function automatic int unsigned long_cnt(input int unsigned clk_freq_hz,
                                             input int unsigned long_ms);
        return clk_freq_hz / 1000 * long_ms;
    endfunction

    // $clog2(n) bits hold 0..n-1; a count of 1 still needs a 1-bit register.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ----------------------------------------------------------------------------
// key_debounce_ch
//   One debounce channel: 2-flop synchronizer, four-state debounce FSM with a
//   saturating stable-time counter and, when KEY_LONG_PRESS_EN is defined, a
//   long-press counter that emits a single pulse per press.
//
//   Parameters
//     DB_CNT      cycles the synchronized input must be stable
//     LONG_CNT    cycles held before key_long pulses (macro build only)
//   Ports
//     sys_clk     clock, rising edge
//     sys_rst     asynchronous active-high reset
//     key         raw button, active-low
//     key_level   debounced state, 1 = pressed
//     key_press   one-cycle pulse on debounced press
//     key_release one-cycle pulse on debounced release
//     key_long    one-cycle pulse when a press lasts LONG_CNT cycles
//
//   Build option: KEY_LONG_PRESS_EN enables the long-press counter; without
//   it key_long is constant 0.
// ----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DB_CNT   = 5,
    parameter int unsigned LONG_CNT = 20
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int unsigned    DB_W    = cnt_width(DB_CNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

    logic [1:0]      sync;
    logic            s;
    key_state_t      state;
    logic [DB_W-1:0] cnt;

    // Synchronizer resets to the released level so a reset never looks like
    // a press edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], key};
        end
    end

    assign s = sync[1];

    // The state that accepts the edge clears the counter; the waiting state
    // then needs DB_CNT consecutive matching samples, the last of which
    // triggers the transition, so the counter never exceeds DB_CNT-1.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE_UP;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state)
                IDLE_UP: begin
                    cnt <= '0;
                    if (!s) begin
                        state <= WAIT_DOWN;
                    end
                end
                WAIT_DOWN: begin
                    if (s) begin
                        state <= IDLE_UP;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD_DOWN;
                        cnt       <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD_DOWN: begin
                    cnt <= '0;
                    if (s) begin
                        state <= WAIT_UP;
                    end
                end
                WAIT_UP: begin
                    if (!s) begin
                        state <= HELD_DOWN;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE_UP;
                        cnt         <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned      LONG_W    = cnt_width(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic [LONG_W-1:0] long_cnt_q;
    logic              long_done;

    // Counts cycles spent in HELD_DOWN (paused while a release is being
    // qualified). It parks at LONG_CNT-1; long_done keeps the pulse to one
    // per press and is only cleared once the key is fully released.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            long_cnt_q <= '0;
            long_done  <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_long <= 1'b0;
            case (state)
                IDLE_UP: begin
                    long_cnt_q <= '0;
                    long_done  <= 1'b0;
                end
                HELD_DOWN: begin
                    if (long_cnt_q == LONG_LAST) begin
                        if (!long_done) begin
                            key_long <= 1'b1;
                        end
                        long_done <= 1'b1;
                    end else begin
                        long_cnt_q <= long_cnt_q + 1'b1;
                    end
                end
                default: begin
                    long_cnt_q <= long_cnt_q;
                end
            endcase
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//   Four independent debounced push-buttons with press / release pulses and
//   an optional long-press pulse.
//
//   Parameters
//     CLK_FREQ_HZ  sys_clk frequency in Hz
//     DEBOUNCE_MS  required stable time in ms
//     LONG_MS      long-press threshold in ms
//   Ports
//     sys_clk      clock, rising edge
//     sys_rst      asynchronous active-high reset
//     key[3:0]     raw buttons, active-low
//     key_level    debounced state, 1 = pressed
//     key_press    one-cycle pulse per debounced press
//     key_release  one-cycle pulse per debounced release
//     key_long     one-cycle pulse when a press reaches the long threshold
//
//   Build option: KEY_LONG_PRESS_EN enables long-press detection; otherwise
//   key_long is tied to 0.
// ----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    localparam int unsigned DB_CNT   = db_cnt(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CNT = long_cnt(CLK_FREQ_HZ, LONG_MS);

    for (genvar i = 0; i < KEY_W; i++) begin : g_ch
        key_debounce_ch #(
            .DB_CNT   (DB_CNT),
            .LONG_CNT (LONG_CNT)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .key         (key[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [3:0] key     = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_long;

    always #5 sys_clk = ~sys_clk;

    key_debounce #(
        .CLK_FREQ_HZ (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    typedef struct {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } exp_t;

    typedef struct {
        string       name;
        int unsigned len;
    } test_t;

    typedef struct {
        int unsigned test;
        int unsigned start;
        logic [3:0]  k;
    } seg_t;

    typedef struct {
        int unsigned test;
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  lng;
    } ev_t;

    exp_t        sb[$];
    test_t       tests[$];
    seg_t        segs[$];
    ev_t         evs[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        cmp({tag, " key_level"},   key_level,   e.level);
        cmp({tag, " key_press"},   key_press,   e.press);
        cmp({tag, " key_release"}, key_release, e.rel);
        cmp({tag, " key_long"},    key_long,    e.lng);
    endtask

    // Push the expectation, let the DUT clock once, pop and compare mid-cycle.
    task automatic step(input exp_t e, input string tag);
        exp_t got;
        sb.push_back(e);
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty expected 1 entry", tag);
        end else begin
            got = sb.pop_front();
            check_all(tag, got);
        end
    endtask

    // Leaves the bench at a negedge with reset just released.
    task automatic do_reset(input string tag);
        exp_t z;
        z = '{level: 4'h0, press: 4'h0, rel: 4'h0, lng: 4'h0};
        @(negedge sys_clk);
        sys_rst = 1'b1;
        key     = 4'hF;
        #1;
        check_all({tag, " in reset"}, z);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        exp_t        e;
        exp_t        z;
        logic [3:0]  lvl;
        logic [3:0]  k;
        string       tag;

        z = '{level: 4'h0, press: 4'h0, rel: 4'h0, lng: 4'h0};

        // Cycle c = c-th rising edge after reset release; key for cycle c is
        // applied just before that edge.
        tests.push_back('{name: "clean",   len: 12});
        segs.push_back('{test: 0, start: 0, k: 4'b1110});
        evs.push_back('{test: 0, cyc: 7, press: 4'b0001, rel: 4'b0000, lng: 4'b0000});

        tests.push_back('{name: "bounce",  len: 16});
        segs.push_back('{test: 1, start: 0, k: 4'b1101});
        segs.push_back('{test: 1, start: 3, k: 4'b1111});
        segs.push_back('{test: 1, start: 4, k: 4'b1101});
        evs.push_back('{test: 1, cyc: 11, press: 4'b0010, rel: 4'b0000, lng: 4'b0000});

        tests.push_back('{name: "relglitch", len: 34});
        segs.push_back('{test: 2, start: 0,  k: 4'b1011});
        segs.push_back('{test: 2, start: 15, k: 4'b1111});
        segs.push_back('{test: 2, start: 18, k: 4'b1011});
        evs.push_back('{test: 2, cyc: 7, press: 4'b0100, rel: 4'b0000, lng: 4'b0000});
`ifdef KEY_LONG_PRESS_EN
        // Long counter paused for the 3 WAIT_UP cycles, so 27 + 3.
        evs.push_back('{test: 2, cyc: 30, press: 4'b0000, rel: 4'b0000, lng: 4'b0100});
`endif

        tests.push_back('{name: "long",    len: 52});
        segs.push_back('{test: 3, start: 0,  k: 4'b0111});
        segs.push_back('{test: 3, start: 40, k: 4'b1111});
        evs.push_back('{test: 3, cyc: 7,  press: 4'b1000, rel: 4'b0000, lng: 4'b0000});
        evs.push_back('{test: 3, cyc: 47, press: 4'b0000, rel: 4'b1000, lng: 4'b0000});
`ifdef KEY_LONG_PRESS_EN
        evs.push_back('{test: 3, cyc: 27, press: 4'b0000, rel: 4'b0000, lng: 4'b1000});
`endif

        tests.push_back('{name: "all4",    len: 22});
        segs.push_back('{test: 4, start: 0,  k: 4'b0000});
        segs.push_back('{test: 4, start: 10, k: 4'b1111});
        evs.push_back('{test: 4, cyc: 7,  press: 4'b1111, rel: 4'b0000, lng: 4'b0000});
        evs.push_back('{test: 4, cyc: 17, press: 4'b0000, rel: 4'b1111, lng: 4'b0000});

        for (int t = 0; t < tests.size(); t++) begin
            do_reset(tests[t].name);
            lvl = 4'h0;
            k   = 4'hF;
            for (int unsigned c = 0; c < tests[t].len; c++) begin
                foreach (segs[i]) begin
                    if (segs[i].test == t && segs[i].start == c) k = segs[i].k;
                end
                key = k;
                e = z;
                foreach (evs[i]) begin
                    if (evs[i].test == t && evs[i].cyc == c) begin
                        e.press |= evs[i].press;
                        e.rel   |= evs[i].rel;
                        e.lng   |= evs[i].lng;
                    end
                end
                lvl     = (lvl | e.press) & ~e.rel;
                e.level = lvl;
                step(e, $sformatf("%s c%0d", tests[t].name, c));
            end
        end

        // Reset in the middle of a hold: no release, then a fresh press
        // from keys still held through reset release.
        do_reset("midhold");
        key = 4'b0000;
        for (int unsigned c = 0; c < 15; c++) begin
            e = z;
            if (c == 7) e.press = 4'b1111;
            if (c >= 7) e.level = 4'b1111;
            step(e, $sformatf("midhold c%0d", c));
        end
        sys_rst = 1'b1;
        #1;
        check_all("midhold rst async", z);
        for (int unsigned c = 0; c < 2; c++) begin
            step(z, $sformatf("midhold rst c%0d", c));
        end
        sys_rst = 1'b0;
        for (int unsigned c = 0; c < 12; c++) begin
            e = z;
            if (c == 7) e.press = 4'b1111;
            if (c >= 7) e.level = 4'b1111;
            step(e, $sformatf("midhold post c%0d", c));
        end

        // Reset in the middle of a debounce, then key released: silent.
        do_reset("middb");
        key = 4'b1110;
        for (int unsigned c = 0; c < 5; c++) begin
            step(z, $sformatf("middb c%0d", c));
        end
        sys_rst = 1'b1;
        #1;
        check_all("middb rst async", z);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        key     = 4'hF;
        for (int unsigned c = 0; c < 12; c++) begin
            step(z, $sformatf("middb post c%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL provide parameter CLK_FREQ_HZ, default 50_000_000, as the sys_clk frequency in Hz.
REQ-002 The block SHALL provide parameter DEBOUNCE_MS, default 20, as the required stable time in ms; DB_CNT = CLK_FREQ_HZ/1000*DEBOUNCE_MS cycles.
REQ-003 The block SHALL provide parameter LONG_MS, default 1000, as the long-press threshold in ms; LONG_CNT = CLK_FREQ_HZ/1000*LONG_MS cycles.
REQ-004 The block SHALL provide port sys_clk, input, 1 bit, as the single clock, all logic rising-edge.
REQ-005 The block SHALL provide port sys_rst, input, 1 bit, as the asynchronous, active-high reset.
REQ-006 The block SHALL provide port key, input, 4 bits, as the raw asynchronous buttons, active-low (0 = pressed).
REQ-007 The block SHALL provide port key_level, output, 4 bits, as the debounced state, 1 = pressed.
REQ-008 The block SHALL provide port key_press, output, 4 bits, as a one-cycle pulse per debounced press.
REQ-009 The block SHALL provide port key_release, output, 4 bits, as a one-cycle pulse per debounced release.
REQ-010 The block SHALL provide port key_long, output, 4 bits, as a one-cycle pulse when a press reaches LONG_CNT.

Function
REQ-011 Each key bit SHALL pass through a 2-flop synchronizer before use, and the synchronizer output is called s.
REQ-012 Each channel SHALL run an independent FSM with states IDLE_UP, WAIT_DOWN, HELD_DOWN and WAIT_UP, plus a debounce counter sized $clog2(DB_CNT).
REQ-013 In IDLE_UP, s=0 SHALL move the channel to WAIT_DOWN with the counter at 0.
REQ-014 In WAIT_DOWN, s=1 SHALL return the channel to IDLE_UP and clear the counter; no output pulse is produced.
REQ-015 In WAIT_DOWN, when s has been 0 for DB_CNT consecutive cycles, the channel SHALL move to HELD_DOWN, set key_level=1 and pulse key_press for 1 cycle.
REQ-016 The key_press pulse SHALL appear exactly 2+DB_CNT cycles after a clean falling edge on key, counted from the first sampling edge.
REQ-017 HELD_DOWN to WAIT_UP to IDLE_UP SHALL mirror REQ-013 to REQ-015 with polarity inverted; on entry to IDLE_UP, key_level=0 and key_release pulses for 1 cycle.
REQ-018 A glitch shorter than DB_CNT cycles in WAIT_UP SHALL return the channel to HELD_DOWN with no pulses and key_level unchanged.
REQ-019 key_press, key_release and key_long SHALL be registered outputs, never high for 2 consecutive cycles in the same bit.
REQ-020 Simultaneous activity on several keys SHALL be handled fully independently, and several bits may pulse in the same cycle.
REQ-021 Counters SHALL saturate and never wrap.

Reset
REQ-022 While sys_rst=1, all outputs SHALL be 0, all FSMs SHALL be in IDLE_UP, all counters SHALL be 0 and the synchronizer flops SHALL be 1 (released).
REQ-023 If a key is held through deassertion of reset, the channel SHALL perform a full debounce and emit key_press 2+DB_CNT cycles after reset deassertion.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL abort the sequence without emitting a release pulse.

Configuration
REQ-025 With macro KEY_LONG_PRESS_EN defined, a per-channel long counter sized $clog2(LONG_CNT) SHALL count in HELD_DOWN, pause in WAIT_UP, and clear in IDLE_UP.
REQ-026 With KEY_LONG_PRESS_EN defined, key_long SHALL pulse once per press when the long counter reaches LONG_CNT, and never more than once per press.
REQ-027 Without KEY_LONG_PRESS_EN, key_long SHALL be tied to 4'b0000 and no long-counter logic SHALL exist.

Structure
REQ-028 Package key_pkg SHALL hold the FSM state typedef, the key width constant (4) and the DB_CNT/LONG_CNT derivation functions.
REQ-029 Sub-module key_debounce_ch SHALL implement one channel (synchronizer, FSM, counters); key_debounce SHALL instantiate it 4 times.

Verification
REQ-030 The bench SHALL use CLK_FREQ_HZ=1000, DEBOUNCE_MS=5 and LONG_MS=20, giving DB_CNT=5 and LONG_CNT=20.
REQ-031 Clean press: key=4'b1110 from cycle 0 -> key_press=4'b0001 for exactly 1 cycle at cycle 7, and key_level[0]=1 from cycle 7.
REQ-032 Bounce: key[1] toggles low 3 cycles, high 1 cycle, low steady -> exactly one key_press[1], issued 7 cycles after the last falling edge.
REQ-033 Release glitch: key[2] held, then high for 3 cycles, then low again -> no key_release[2], and key_level[2] stays 1.
REQ-034 Long press (macro on): key[3] held for 40 cycles -> key_press[3] at cycle 7, single key_long[3] at cycle 27, then key_release[3] 7 cycles after release; with the macro off, key_long stays 0.
REQ-035 Reset mid-hold: key=4'b0000 held, sys_rst pulsed high at cycle 15 -> outputs 0, no release pulse, and all four key_press bits pulse together 7 cycles after reset falls.
